// File: rtl/ipv4_frame_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : ipv4_frame_tx_param
// Description : Byte-serial Ethernet II / IPv4 frame transmitter. Latches one
//               message, computes the IPv4 header checksum, then streams the
//               Ethernet header, IP header, payload and zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
module ipv4_frame_tx_param #(
  parameter int MSG_WIDTH       = 10,
  parameter int IP_TTL          = 64,
  parameter int IP_PROTOCOL     = 17,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [31:0]          ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]          ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0]          RECIPIENT_IP_ADDRESS,
  input  logic [47:0]          RECIPIENT_MAC_ADDRESS,
  input  logic [MSG_WIDTH-1:0] RECIPIENT_MESSAGE,
  input  logic                 START_IP_TXN,
  output logic                 READY_FOR_SEND,
  output logic [7:0]           MAC_DATA_OUT,
  input  logic                 MAC_DATA_READY,
  output logic                 MAC_DATA_VALID,
  output logic                 MAC_DATA_FIRST,
  output logic                 MAC_DATA_LAST
);

  localparam int c_PAYLOAD_BYTES = (MSG_WIDTH + 7) / 8;
  localparam int c_PAY_W         = c_PAYLOAD_BYTES * 8;
  localparam int c_PAY_IW        = $clog2(c_PAY_W);
  localparam int c_DATA_END      = 34 + c_PAYLOAD_BYTES;
  localparam int c_FRAME_BYTES   = (c_DATA_END > MIN_FRAME_BYTES) ? c_DATA_END : MIN_FRAME_BYTES;

  localparam logic [15:0] c_TOTAL_LEN    = 16'(20 + c_PAYLOAD_BYTES);
  localparam logic [15:0] c_TTL_PROTO    = {8'(IP_TTL), 8'(IP_PROTOCOL)};
  localparam logic [15:0] c_LAST_IDX     = 16'(c_FRAME_BYTES - 1);
  localparam logic [15:0] c_PAY_LAST_IDX = 16'(c_DATA_END - 1);
  localparam logic [15:0] c_DATA_END16   = 16'(c_DATA_END);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CSUM    = 3'd1,
    S_FOLD    = 3'd2,
    S_ETH_HDR = 3'd3,
    S_IP_HDR  = 3'd4,
    S_PAYLOAD = 3'd5,
    S_PAD     = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [15:0]          r_cnt;
  logic [3:0]           r_idx;
  logic [31:0]          r_acc;
  logic [15:0]          r_csum;
  logic [15:0]          r_ident;
  logic [31:0]          r_src_ip;
  logic [31:0]          r_dst_ip;
  logic [47:0]          r_src_mac;
  logic [47:0]          r_dst_mac;
  logic [c_PAY_W-1:0]   r_msg;

  logic                 w_valid;
  logic                 w_first;
  logic                 w_last;
  logic [7:0]           w_data;
  logic                 w_xfer;
  logic [15:0]          w_word;
  logic [16:0]          w_fold1;
  logic [15:0]          w_fold2;
  logic [271:0]         w_hdr;
  logic [8:0]           w_hdr_bit;
  logic [15:0]          w_pay_sel;
  logic [c_PAY_IW-1:0]  w_pay_bit;

  // Header bytes packed MS-first so byte N sits at bit (33-N)*8
  assign w_hdr = {r_dst_mac, r_src_mac, 16'h0800, 16'h4500, c_TOTAL_LEN, r_ident,
                  16'h4000, c_TTL_PROTO, r_csum, r_src_ip, r_dst_ip};
  assign w_hdr_bit = 9'({16'd33 - r_cnt, 3'b000});
  // Payload byte index counted from the LS end: (33 + PAYLOAD_BYTES) - cnt
  assign w_pay_sel = c_PAY_LAST_IDX - r_cnt;
  assign w_pay_bit = c_PAY_IW'({w_pay_sel, 3'b000});

  // Two-stage end-around-carry fold; the second add cannot overflow
  assign w_fold1 = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
  assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

  // Checksum word sequence, one word per CSUM cycle
  always_comb begin
    w_word = 16'h0000;
    case (r_idx)
      4'd0: w_word = 16'h4500;
      4'd1: w_word = c_TOTAL_LEN;
      4'd2: w_word = r_ident;
      4'd3: w_word = 16'h4000;
      4'd4: w_word = c_TTL_PROTO;
      4'd5: w_word = 16'h0000;
      4'd6: w_word = r_src_ip[31:16];
      4'd7: w_word = r_src_ip[15:0];
      4'd8: w_word = r_dst_ip[31:16];
      4'd9: w_word = r_dst_ip[15:0];
      default: w_word = 16'h0000;
    endcase
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and stream outputs, decoded from registered state/counter only
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_first      = 1'b0;
    w_last       = 1'b0;
    w_data       = 8'h00;
    w_xfer       = 1'b0;

    if (r_state == S_ETH_HDR || r_state == S_IP_HDR ||
        r_state == S_PAYLOAD || r_state == S_PAD) begin
      w_valid = 1'b1;
      w_first = (r_cnt == 16'd0);
      w_last  = (r_cnt == c_LAST_IDX);
      if (r_cnt < 16'd34) begin
        w_data = w_hdr[w_hdr_bit +: 8];
      end else if (r_cnt < c_DATA_END16) begin
        w_data = r_msg[w_pay_bit +: 8];
      end
    end
    w_xfer = w_valid && MAC_DATA_READY;

    case (r_state)
      S_IDLE: begin
        if (START_IP_TXN) begin
          w_next_state = S_CSUM;
        end
      end
      S_CSUM: begin
        if (r_idx == 4'd9) begin
          w_next_state = S_FOLD;
        end
      end
      S_FOLD: begin
        w_next_state = S_ETH_HDR;
      end
      default: begin
        if (w_xfer) begin
          if (r_cnt == c_LAST_IDX) begin
            w_next_state = S_IDLE;
          end else if (r_cnt == 16'd13) begin
            w_next_state = S_IP_HDR;
          end else if (r_cnt == 16'd33) begin
            w_next_state = S_PAYLOAD;
          end else if (r_cnt == c_PAY_LAST_IDX) begin
            w_next_state = S_PAD;
          end
        end
      end
    endcase
  end

  // Datapath: latch on accept, accumulate checksum, count transferred bytes
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cnt     <= 16'd0;
      r_idx     <= 4'd0;
      r_acc     <= 32'd0;
      r_csum    <= 16'd0;
      r_ident   <= 16'd0;
      r_src_ip  <= 32'd0;
      r_dst_ip  <= 32'd0;
      r_src_mac <= 48'd0;
      r_dst_mac <= 48'd0;
      r_msg     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START_IP_TXN) begin
            r_src_ip  <= ACCELERATOR_IP_ADDRESS;
            r_dst_ip  <= RECIPIENT_IP_ADDRESS;
            r_src_mac <= ACCELERATOR_MAC_ADDRESS;
            r_dst_mac <= RECIPIENT_MAC_ADDRESS;
            r_msg     <= c_PAY_W'(RECIPIENT_MESSAGE);
            r_acc     <= 32'd0;
            r_idx     <= 4'd0;
            r_cnt     <= 16'd0;
          end
        end
        S_CSUM: begin
          r_acc <= r_acc + {16'd0, w_word};
          r_idx <= r_idx + 4'd1;
        end
        S_FOLD: begin
          r_csum <= ~w_fold2;
        end
        default: begin
          if (w_xfer) begin
            if (r_cnt == c_LAST_IDX) begin
              r_cnt   <= 16'd0;
              r_ident <= r_ident + 16'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign READY_FOR_SEND = (r_state == S_IDLE);
  assign MAC_DATA_OUT   = w_data;
  assign MAC_DATA_VALID = w_valid;
  assign MAC_DATA_FIRST = w_first;
  assign MAC_DATA_LAST  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_ipv4_frame_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipv4_frame_tx_param
// Description : Self-checking bench for ipv4_frame_tx_param (default build and
//               a 512-bit message build), directed vectors plus a byte model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipv4_frame_tx_param;

  logic         aclk = 1'b0;
  logic         areset;
  logic [31:0]  src_ip, dst_ip;
  logic [47:0]  src_mac, dst_mac;
  logic [9:0]   msg_a;
  logic [511:0] msg_b;
  logic         start_a, start_b, rdy;
  logic         ready_a, valid_a, first_a, last_a;
  logic         ready_b, valid_b, first_b, last_b;
  logic [7:0]   data_a, data_b;

  always #5 aclk = ~aclk;

  ipv4_frame_tx_param dut (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
    .RECIPIENT_IP_ADDRESS(dst_ip), .RECIPIENT_MAC_ADDRESS(dst_mac),
    .RECIPIENT_MESSAGE(msg_a), .START_IP_TXN(start_a), .READY_FOR_SEND(ready_a),
    .MAC_DATA_OUT(data_a), .MAC_DATA_READY(rdy), .MAC_DATA_VALID(valid_a),
    .MAC_DATA_FIRST(first_a), .MAC_DATA_LAST(last_a)
  );

  ipv4_frame_tx_param #(.MSG_WIDTH(512), .MIN_FRAME_BYTES(60)) dut_w (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
    .RECIPIENT_IP_ADDRESS(dst_ip), .RECIPIENT_MAC_ADDRESS(dst_mac),
    .RECIPIENT_MESSAGE(msg_b), .START_IP_TXN(start_b), .READY_FOR_SEND(ready_b),
    .MAC_DATA_OUT(data_b), .MAC_DATA_READY(rdy), .MAC_DATA_VALID(valid_b),
    .MAC_DATA_FIRST(first_b), .MAC_DATA_LAST(last_b)
  );

  // Selected instance view
  logic       sel_b;
  logic       m_v, m_f, m_l, m_rfs;
  logic [7:0] m_d;
  always_comb begin
    m_v   = sel_b ? valid_b : valid_a;
    m_f   = sel_b ? first_b : first_a;
    m_l   = sel_b ? last_b  : last_a;
    m_d   = sel_b ? data_b  : data_a;
    m_rfs = sel_b ? ready_b : ready_a;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Captured and expected frames
  logic [7:0] cap_data  [0:255];
  logic       cap_first [0:255];
  logic       cap_last  [0:255];
  int         cap_n;
  logic [7:0] exp_data  [0:255];
  int         exp_n;
  logic [7:0] pay_a [0:63];
  logic [7:0] pay_b [0:63];

  // Reference frame builder; checksum uses per-add end-around carry
  function automatic void build(input int pb, input logic [7:0] pay [0:63], input logic [15:0] ident);
    logic [15:0] words [0:9];
    logic [15:0] tl;
    logic [15:0] cs;
    int s;
    int k;
    tl = 16'(20 + pb);
    words = '{16'h4500, tl, ident, 16'h4000, 16'h4011, 16'h0000,
              src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0]};
    s = 0;
    for (int i = 0; i < 10; i++) begin
      s = s + int'(words[i]);
      if (s > 65535) s = s - 65535;
    end
    cs = ~16'(s);
    k = 0;
    for (int i = 0; i < 6; i++) begin exp_data[k] = dst_mac[47-8*i -: 8]; k++; end
    for (int i = 0; i < 6; i++) begin exp_data[k] = src_mac[47-8*i -: 8]; k++; end
    exp_data[k] = 8'h08; k++; exp_data[k] = 8'h00; k++;
    exp_data[k] = 8'h45; k++; exp_data[k] = 8'h00; k++;
    exp_data[k] = tl[15:8]; k++; exp_data[k] = tl[7:0]; k++;
    exp_data[k] = ident[15:8]; k++; exp_data[k] = ident[7:0]; k++;
    exp_data[k] = 8'h40; k++; exp_data[k] = 8'h00; k++;
    exp_data[k] = 8'h40; k++; exp_data[k] = 8'h11; k++;
    exp_data[k] = cs[15:8]; k++; exp_data[k] = cs[7:0]; k++;
    for (int i = 0; i < 4; i++) begin exp_data[k] = src_ip[31-8*i -: 8]; k++; end
    for (int i = 0; i < 4; i++) begin exp_data[k] = dst_ip[31-8*i -: 8]; k++; end
    for (int i = 0; i < pb; i++) begin exp_data[k] = pay[i]; k++; end
    while (k < 60) begin exp_data[k] = 8'h00; k++; end
    exp_n = k;
  endfunction

  // Request a frame from the selected instance; returns in the cycle after accept
  task automatic start_frame();
    @(negedge aclk);
    check("accept_ready", m_rfs, 1'b1);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge aclk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_accept", m_rfs, 1'b0);
  endtask

  // Collect one frame; optional random READY and a START pulse at byte pulse_at
  task automatic capture(input bit rand_rdy, input int pulse_at);
    bit         done;
    bit         prev_stall;
    bit         pulsed;
    logic [7:0] pd;
    logic       pf, pl;
    done = 1'b0; prev_stall = 1'b0; pulsed = 1'b0;
    pd = 8'h00; pf = 1'b0; pl = 1'b0;
    cap_n = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (prev_stall) check("stall_hold", {m_v, m_f, m_l, m_d}, {1'b1, pf, pl, pd});
      else if (cap_n > 0) check("no_bubble", m_v, 1'b1);
      if (pulse_at >= 0) begin
        if (cap_n == pulse_at && !pulsed) begin
          start_a = 1'b1;
          pulsed  = 1'b1;
          check("busy_ready_low", m_rfs, 1'b0);
        end else begin
          start_a = 1'b0;
        end
      end
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_v && rdy) begin
        if (cap_n < 256) begin
          cap_data[cap_n]  = m_d;
          cap_first[cap_n] = m_f;
          cap_last[cap_n]  = m_l;
        end
        cap_n++;
        if (m_l) done = 1'b1;
      end
      prev_stall = m_v && !rdy;
      pd = m_d; pf = m_f; pl = m_l;
      if (done) break;
      @(negedge aclk);
    end
    rdy = 1'b1;
    start_a = 1'b0;
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL frame_timeout: actual %0d bytes without LAST, required LAST within budget", cap_n);
    end
  endtask

  task automatic compare_frame(input string name);
    int bad;
    bad = 0;
    check({name, "_len"}, 64'(cap_n), 64'(exp_n));
    for (int i = 0; i < exp_n && i < 256; i++) begin
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== (i == 0) ||
          cap_last[i] !== (i == exp_n - 1)) bad++;
    end
    check({name, "_bad_bytes"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t t1 [0:22];

  initial begin
    int k;
    int nb;
    bit hit;

    t1 = '{'{0, 8'hFF}, '{5, 8'hFF}, '{6, 8'h02}, '{11, 8'h01}, '{12, 8'h08},
           '{13, 8'h00}, '{14, 8'h45}, '{15, 8'h00}, '{16, 8'h00}, '{17, 8'h16},
           '{18, 8'h00}, '{19, 8'h00}, '{20, 8'h40}, '{22, 8'h40}, '{23, 8'h11},
           '{24, 8'hB7}, '{25, 8'h7B}, '{26, 8'hC0}, '{33, 8'h01}, '{34, 8'h02},
           '{35, 8'hA5}, '{36, 8'h00}, '{59, 8'h00}};

    src_ip  = 32'hC0A8010A; src_mac = 48'h020000000001;
    dst_ip  = 32'hC0A80101; dst_mac = 48'hFFFFFFFFFFFF;
    msg_a   = 10'h2A5;
    for (int i = 0; i < 64; i++) begin
      msg_b[511-8*i -: 8] = 8'(i + 1);
      pay_b[i] = 8'(i + 1);
      pay_a[i] = 8'h00;
    end
    pay_a[0] = 8'h02; pay_a[1] = 8'hA5;
    start_a = 1'b0; start_b = 1'b0; rdy = 1'b1; sel_b = 1'b0;

    // Reset state
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_ready", ready_a, 1'b1);
    check("rst_valid", valid_a, 1'b0);
    check("rst_first", first_a, 1'b0);
    check("rst_last",  last_a,  1'b0);
    check("rst_data",  data_a,  8'h00);
    areset = 1'b0;

    // 1: default frame, READY held high, latency and hand-computed bytes
    start_frame();
    src_ip = 32'h0; msg_a = 10'h0;      // late input changes must not leak into the frame
    k = 1;
    while (!m_v && k < 30) begin
      @(negedge aclk);
      k++;
    end
    check("first_valid_cycle", 64'(k), 64'd12);
    capture(1'b0, -1);
    src_ip = 32'hC0A8010A; msg_a = 10'h2A5;
    check("t1_len", 64'(cap_n), 64'd60);
    for (int i = 0; i < 23; i++) check($sformatf("t1_byte%0d", t1[i].pos), cap_data[t1[i].pos], t1[i].exp);
    check("t1_first0", cap_first[0], 1'b1);
    check("t1_last59", cap_last[59], 1'b1);
    build(2, pay_a, 16'h0000);
    compare_frame("t1_model");

    // 2: same frame under random READY back-pressure
    start_frame();
    capture(1'b1, -1);
    build(2, pay_a, 16'h0001);
    compare_frame("t2_model");
    check("t2_csum_hi", cap_data[24], 8'hB7);
    check("t2_csum_lo", cap_data[25], 8'h7A);

    // 3: back-to-back frames, START during frame 1 ignored
    @(negedge aclk); areset = 1'b1;
    @(negedge aclk); areset = 1'b0;
    start_frame();
    capture(1'b0, 30);
    build(2, pay_a, 16'h0000);
    compare_frame("t3_f1_model");
    start_a = 1'b1;
    @(negedge aclk);
    check("b2b_ready", ready_a, 1'b1);
    @(negedge aclk);
    start_a = 1'b0;
    check("b2b_accepted", ready_a, 1'b0);
    capture(1'b0, -1);
    check("t3_ident_lo", cap_data[19], 8'h01);
    check("t3_csum_lo", cap_data[25], 8'h7A);
    build(2, pay_a, 16'h0001);
    compare_frame("t3_f2_model");

    // 4: 512-bit message, no padding
    sel_b = 1'b1;
    start_frame();
    capture(1'b0, -1);
    check("t4_len", 64'(cap_n), 64'd98);
    check("t4_tl_hi", cap_data[16], 8'h00);
    check("t4_tl_lo", cap_data[17], 8'h54);
    check("t4_last97", cap_last[97], 1'b1);
    check("t4_lastbyte", cap_data[97], 8'h40);
    build(64, pay_b, 16'h0000);
    compare_frame("t4_model");
    sel_b = 1'b0;

    // 5: reset at IP header byte 5 (frame byte 19)
    start_frame();
    nb = 0; hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_v) begin
        if (nb == 19) begin hit = 1'b1; break; end
        nb++;
      end
      @(negedge aclk);
    end
    check("t5_reached", hit, 1'b1);
    check("t5_ident_before", data_a, 8'h02);
    areset = 1'b1;
    @(negedge aclk);
    check("t5_valid_low", valid_a, 1'b0);
    check("t5_last_low", last_a, 1'b0);
    check("t5_ready_high", ready_a, 1'b1);
    areset = 1'b0;
    start_frame();
    capture(1'b0, -1);
    build(2, pay_a, 16'h0000);
    compare_frame("t5_model");

    // 6: identification wrap
    @(negedge aclk);
    dut.r_ident = 16'hFFFF;
    start_frame();
    capture(1'b0, -1);
    check("t6_ident_hi", cap_data[18], 8'hFF);
    check("t6_ident_lo", cap_data[19], 8'hFF);
    check("t6_csum_hi", cap_data[24], 8'hB7);
    check("t6_csum_lo", cap_data[25], 8'h7B);
    build(2, pay_a, 16'hFFFF);
    compare_frame("t6_model");
    start_frame();
    capture(1'b0, -1);
    check("t6_wrap_hi", cap_data[18], 8'h00);
    check("t6_wrap_lo", cap_data[19], 8'h00);
    build(2, pay_a, 16'h0000);
    compare_frame("t6_wrap_model");

    repeat (3) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
